// File: rtl/tdp_ram_be.sv
// True dual-port byte-enabled RAM with request/valid handshake, misalignment flags
// and a clear engine that zeroes the array after reset or on a clr pulse.
module tdp_ram_be #(
    parameter int unsigned DATAW          = 32,
    parameter int unsigned ADDRW          = 12,
    parameter int unsigned WORD_LEN       = 2,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned RDW_MODE       = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    output logic                 ready,
    input  logic                 ena,
    input  logic                 wea,
    input  logic [DATAW/8-1:0]   bea,
    input  logic [ADDRW-1:0]     addra,
    input  logic [DATAW-1:0]     dina,
    output logic [DATAW-1:0]     douta,
    output logic                 rvalida,
    output logic                 misaligna,
    input  logic                 enb,
    input  logic                 web,
    input  logic [DATAW/8-1:0]   beb,
    input  logic [ADDRW-1:0]     addrb,
    input  logic [DATAW-1:0]     dinb,
    output logic [DATAW-1:0]     doutb,
    output logic                 rvalidb,
    output logic                 misalignb
);

    localparam int unsigned NB    = DATAW / 8;
    localparam int unsigned AW    = ADDRW - WORD_LEN;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

    state_e                    state_q;
    logic                      ready_q;
    logic [AW-1:0]             cnt_q;

    logic [DATAW-1:0]          mem_q [DEPTH];

    // Per-port request view; index 0 is port A, index 1 is port B.
    logic [1:0]                en_c, we_c, off_c, acc_c, wr_c, rd_c;
    logic [1:0][NB-1:0]        be_c;
    logic [1:0][AW-1:0]        idx_c;
    logic [1:0][DATAW-1:0]     din_c, post_c;
    logic                      same_c;

    logic [1:0]                s1_vld_q, s1_mis_q;
    logic [1:0][DATAW-1:0]     s1_dat_q;
    logic [1:0]                out_vld_c;
    logic [1:0][DATAW-1:0]     out_dat_c;
    logic [1:0]                rvalid_q, mis_q;
    logic [1:0][DATAW-1:0]     dout_q;

    // Clear engine: walk every word once, then accept requests.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            ready_q <= (CLEAR_ON_RESET == 0);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_RUN: begin
                    if (clr) begin
                        state_q <= ST_CLEAR;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ready_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // post_c is the word as it will look after this edge's writes (A wins overlaps).
    always_comb begin
        en_c   = {enb, ena};
        we_c   = {web, wea};
        be_c   = {beb, bea};
        din_c  = {dinb, dina};
        idx_c  = {addrb[ADDRW-1:WORD_LEN], addra[ADDRW-1:WORD_LEN]};
        off_c  = {|addrb[WORD_LEN-1:0], |addra[WORD_LEN-1:0]};
        acc_c  = en_c & {2{ready_q}};
        wr_c   = acc_c & we_c;
        rd_c   = acc_c & (~we_c | {2{RDW_MODE != 0}});
        same_c = (idx_c[0] == idx_c[1]);
        post_c[0] = mem_q[idx_c[0]];
        post_c[1] = mem_q[idx_c[1]];
        for (int i = 0; i < NB; i++) begin
            if (wr_c[1] && be_c[1][i]) begin
                post_c[1][8*i +: 8] = din_c[1][8*i +: 8];
                if (same_c) post_c[0][8*i +: 8] = din_c[1][8*i +: 8];
            end
            if (wr_c[0] && be_c[0][i]) begin
                post_c[0][8*i +: 8] = din_c[0][8*i +: 8];
                if (same_c) post_c[1][8*i +: 8] = din_c[0][8*i +: 8];
            end
        end
    end

    // Array: clear writes while clearing, otherwise byte writes with B first so A overrides.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_c[1] && be_c[1][i]) mem_q[idx_c[1]][8*i +: 8] <= din_c[1][8*i +: 8];
                if (wr_c[0] && be_c[0][i]) mem_q[idx_c[0]][8*i +: 8] <= din_c[0][8*i +: 8];
            end
        end
    end

    // Optional extra output stage for the 2-cycle latency variant.
    if (OUT_REG != 0) begin : g_oreg
        logic [1:0]            s2_vld_q;
        logic [1:0][DATAW-1:0] s2_dat_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                s2_vld_q <= '0;
                s2_dat_q <= '0;
            end else begin
                s2_vld_q <= s1_vld_q;
                for (int p = 0; p < 2; p++) begin
                    if (s1_vld_q[p]) s2_dat_q[p] <= s1_dat_q[p];
                end
            end
        end

        assign out_vld_c = s2_vld_q;
        assign out_dat_c = s2_dat_q;
    end else begin : g_noreg
        assign out_vld_c = s1_vld_q;
        assign out_dat_c = s1_dat_q;
    end

    // Read pipeline: capture the pre-edge (or merged) word, present it one edge later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld_q <= '0;
            s1_mis_q <= '0;
            s1_dat_q <= '0;
            rvalid_q <= '0;
            mis_q    <= '0;
            dout_q   <= '0;
        end else begin
            s1_vld_q <= rd_c;
            s1_mis_q <= acc_c & off_c;
            rvalid_q <= out_vld_c;
            mis_q    <= s1_mis_q;
            for (int p = 0; p < 2; p++) begin
                if (rd_c[p]) s1_dat_q[p] <= we_c[p] ? post_c[p] : mem_q[idx_c[p]];
                if (out_vld_c[p]) dout_q[p] <= out_dat_c[p];
            end
        end
    end

    assign ready     = ready_q;
    assign douta     = dout_q[0];
    assign doutb     = dout_q[1];
    assign rvalida   = rvalid_q[0];
    assign rvalidb   = rvalid_q[1];
    assign misaligna = mis_q[0];
    assign misalignb = mis_q[1];

endmodule

// File: tb/tb_tdp_ram_be.sv
// Bench for tdp_ram_be: two instances (default, and OUT_REG=1/RDW_MODE=1) driven in
// lockstep against a byte-level reference model with a per-channel scoreboard.
module tb_tdp_ram_be;

    localparam int unsigned DEPTH = 1024;

    typedef struct packed {
        logic        en;
        logic        we;
        logic [3:0]  be;
        logic [11:0] addr;
        logic [31:0] din;
    } req_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clr = 1'b0;
    logic        ena = 1'b0, wea = 1'b0, enb = 1'b0, web = 1'b0;
    logic [3:0]  bea = '0, beb = '0;
    logic [11:0] addra = '0, addrb = '0;
    logic [31:0] dina = '0, dinb = '0;

    logic        rdy0, rva0, rvb0, mia0, mib0;
    logic [31:0] douta0, doutb0;
    logic        rdy1, rva1, rvb1, mia1, mib1;
    logic [31:0] douta1, doutb1;

    tdp_ram_be u_dut0 (
        .clk(clk), .rstn(rstn), .clr(clr), .ready(rdy0),
        .ena(ena), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
        .douta(douta0), .rvalida(rva0), .misaligna(mia0),
        .enb(enb), .web(web), .beb(beb), .addrb(addrb), .dinb(dinb),
        .doutb(doutb0), .rvalidb(rvb0), .misalignb(mib0)
    );

    tdp_ram_be #(.OUT_REG(1), .RDW_MODE(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .clr(clr), .ready(rdy1),
        .ena(ena), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
        .douta(douta1), .rvalida(rva1), .misaligna(mia1),
        .enb(enb), .web(web), .beb(beb), .addrb(addrb), .dinb(dinb),
        .doutb(doutb1), .rvalidb(rvb1), .misalignb(mib1)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model [DEPTH];
    exp_t        sb [4][$];
    int          mq [2][$];
    logic [31:0] last [4];
    bit          exp_ready = 1'b0;
    int          clear_left = DEPTH;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endfunction

    // Channel ch = dut*2 + port.
    task automatic check_chan(input int ch, input logic rv, input logic [31:0] d);
        bit due_now;
        due_now = (sb[ch].size() > 0) && (sb[ch][0].due == cyc);
        chk($sformatf("rvalid_ch%0d", ch), 32'(rv), 32'(due_now));
        if (due_now) begin
            last[ch] = sb[ch][0].data;
            void'(sb[ch].pop_front());
        end
        chk($sformatf("dout_ch%0d", ch), d, last[ch]);
    endtask

    task automatic check_mis(input int p, input logic m0, input logic m1);
        bit due_now;
        due_now = (mq[p].size() > 0) && (mq[p][0] == cyc);
        if (due_now) void'(mq[p].pop_front());
        chk($sformatf("misalign_d0p%0d", p), 32'(m0), 32'(due_now));
        chk($sformatf("misalign_d1p%0d", p), 32'(m1), 32'(due_now));
    endtask

    // Monitor: samples on the falling edge, stimulus changes 1 time unit later.
    always @(negedge clk) begin
        check_chan(0, rva0, douta0);
        check_chan(1, rvb0, doutb0);
        check_chan(2, rva1, douta1);
        check_chan(3, rvb1, doutb1);
        check_mis(0, mia0, mia1);
        check_mis(1, mib0, mib1);
        chk("ready_d0", 32'(rdy0), 32'(exp_ready));
        chk("ready_d1", 32'(rdy1), 32'(exp_ready));
    end

    // Reference behaviour for the coming clock edge, from the currently driven inputs.
    task automatic edge_model();
        int k;
        bit acc_a, acc_b;
        int ia, ib;
        k     = cyc;
        acc_a = ena && exp_ready;
        acc_b = enb && exp_ready;
        ia    = int'(addra) / 4;
        ib    = int'(addrb) / 4;
        if (acc_a && !wea) begin
            sb[0].push_back(exp_t'{due: k + 2, data: model[ia]});
            sb[2].push_back(exp_t'{due: k + 3, data: model[ia]});
        end
        if (acc_b && !web) begin
            sb[1].push_back(exp_t'{due: k + 2, data: model[ib]});
            sb[3].push_back(exp_t'{due: k + 3, data: model[ib]});
        end
        for (int i = 0; i < 4; i++) begin
            if (acc_b && web && beb[i]) model[ib][8*i +: 8] = dinb[8*i +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            if (acc_a && wea && bea[i]) model[ia][8*i +: 8] = dina[8*i +: 8];
        end
        if (acc_a && wea) sb[2].push_back(exp_t'{due: k + 3, data: model[ia]});
        if (acc_b && web) sb[3].push_back(exp_t'{due: k + 3, data: model[ib]});
        if (acc_a && addra[1:0] != 2'b00) mq[0].push_back(k + 2);
        if (acc_b && addrb[1:0] != 2'b00) mq[1].push_back(k + 2);
        if (exp_ready && clr) begin
            exp_ready  = 1'b0;
            clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (!exp_ready) begin
            clear_left--;
            if (clear_left == 0) exp_ready = 1'b1;
        end
    endtask

    task automatic drive(input req_t a, input req_t b, input bit c);
        ena = a.en; wea = a.we; bea = a.be; addra = a.addr; dina = a.din;
        enb = b.en; web = b.we; beb = b.be; addrb = b.addr; dinb = b.din;
        clr = c;
    endtask

    task automatic step(input req_t a, input req_t b, input bit c);
        @(negedge clk);
        #1;
        drive(a, b, c);
        edge_model();
    endtask

    function automatic req_t idle();
        return '0;
    endfunction

    function automatic req_t rd(input logic [11:0] addr);
        req_t r;
        r = '0; r.en = 1'b1; r.addr = addr;
        return r;
    endfunction

    function automatic req_t wr(input logic [11:0] addr, input logic [31:0] din, input logic [3:0] be);
        req_t r;
        r.en = 1'b1; r.we = 1'b1; r.be = be; r.addr = addr; r.din = din;
        return r;
    endfunction

    // Small word range so random traffic collides across ports.
    function automatic req_t rnd_req();
        req_t r;
        logic [1:0] off;
        off    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
        r.en   = 1'($urandom);
        r.we   = 1'($urandom);
        r.be   = 4'($urandom);
        r.addr = {6'd0, 4'($urandom_range(0, 15)), off};
        r.din  = $urandom;
        return r;
    endfunction

    task automatic do_reset(input int hold);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        drive(idle(), idle(), 1'b0);
        for (int i = 0; i < 4; i++) begin
            sb[i].delete();
            last[i] = '0;
        end
        mq[0].delete();
        mq[1].delete();
        exp_ready  = 1'b0;
        clear_left = DEPTH;
        repeat (hold) @(negedge clk);
        #1;
        rstn = 1'b1;
        edge_model();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < 4; i++) last[i] = '0;

        do_reset(3);
        repeat (DEPTH + 2) step(idle(), idle(), 1'b0);

        step(rd(12'h3FC), idle(), 1'b0);
        step(wr(12'h010, 32'hDEADBEEF, 4'b1111), idle(), 1'b0);
        step(wr(12'h010, 32'h000000AA, 4'b0001), idle(), 1'b0);
        step(idle(), rd(12'h010), 1'b0);
        step(wr(12'h020, 32'h11111111, 4'b0011), wr(12'h020, 32'h22222222, 4'b0110), 1'b0);
        step(rd(12'h020), idle(), 1'b0);
        step(wr(12'h040, 32'h12345678, 4'b1111), idle(), 1'b0);
        step(rd(12'h013), rd(12'h010), 1'b0);
        step(wr(12'h010, 32'hCAFEF00D, 4'b1111), rd(12'h010), 1'b0);
        step(rd(12'h010), wr(12'h011, 32'h55555555, 4'b0000), 1'b0);
        step(wr(12'h050, 32'hAAAA5555, 4'b1100), wr(12'h050, 32'h0F0F0F0F, 4'b0110), 1'b0);
        for (int i = 0; i < 8; i++) step(rd(12'(i * 16)), rd(12'(i * 16 + 4)), 1'b0);
        repeat (4) step(idle(), idle(), 1'b0);

        // clr with a concurrent read; random traffic and stray clr during the clear window.
        step(idle(), rd(12'h050), 1'b1);
        repeat (DEPTH) step(rnd_req(), rnd_req(), ($urandom_range(0, 7) == 0));
        for (int i = 0; i < 16; i++) step(rd(12'(i * 4)), idle(), 1'b0);

        // Reset in the middle of a clear restarts the full sweep.
        step(idle(), idle(), 1'b1);
        repeat (300) step(rnd_req(), idle(), 1'b0);
        do_reset(2);
        repeat (DEPTH + 2) step(rnd_req(), rnd_req(), 1'b0);

        repeat (3000) step(rnd_req(), rnd_req(), 1'b0);

        repeat (6) step(idle(), idle(), 1'b0);
        @(negedge clk);
        chk("scoreboard_drain", 32'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()
                                    + mq[0].size() + mq[1].size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdp_ram_be.md
# tdp_ram_be

Parametrised true dual-port RAM with per-byte write enables, byte addressing and selectable read latency, inferred in fabric/BRAM with no vendor IP. It replaces the fixed-size generated dual-port memory in the core's memory subsystem. It adds request/valid signalling, misalignment flags, a defined read-during-write policy and a hardware clear engine that zeroes the array after reset or on demand.

## Interface
- DATAW, 32: word width in bits; must equal 8 << WORD_LEN.
- ADDRW, 12: byte-address width; depth = 2^(ADDRW-WORD_LEN) words.
- WORD_LEN, 2: log2 bytes per word; addr[WORD_LEN-1:0] is the byte offset.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- RDW_MODE, 0: same-port read-during-write; 0 read-first, 1 write-first.
- CLEAR_ON_RESET, 1: 1 runs the clear engine after reset release.

Ports:
- clk  in  1  single clock for both ports
- rstn  in  1  asynchronous, active-low reset
- clr  in  1  single-cycle pulse; starts a clear when the block is in RUN
- ready  out  1  high when requests are accepted (state RUN)
- ena / enb  in  1  port request; accepted when en && ready
- wea / web  in  1  1 = write, 0 = read
- bea / beb  in  DATAW/8  byte enables; ignored on reads
- addra / addrb  in  ADDRW  byte address
- dina / dinb  in  DATAW  write data; byte i is din[8i+7:8i]
- douta / doutb  out  DATAW  read data; holds its value between reads
- rvalida / rvalidb  out  1  one-cycle pulse, coincident with new dout
- misaligna / misalignb  out  1  one-cycle pulse, one cycle after acceptance of an access with a nonzero byte offset

## Operation
- Word index = addr[ADDRW-1:WORD_LEN]. The byte offset is ignored for the access itself; the access proceeds on that word and only the misalign flag reports it.
- Write: the bytes selected by be are updated at the accepting edge. Bytes with be=0 are untouched. A write with be=0 is legal and updates nothing.
- Read: dout returns the full word.
- Same-port write with RDW_MODE=0: no rvalid, dout unchanged.
- Same-port write with RDW_MODE=1: rvalid pulses and dout shows the merged post-write word.
- Cross-port, A writes and B reads the same word in the same cycle: B returns the old word regardless of RDW_MODE. B reading while A writes is symmetric.
- Both ports write the same word in the same cycle: on overlapping enabled bytes, port A wins. B's non-overlapping bytes are still written.
- Clear engine FSM states: CLEAR and RUN.
  - CLEAR: a counter walks words 0 to depth-1, writing all-zero, one word per cycle. ready=0 and all requests are ignored (no rvalid, no misalign).
  - After the final word is written: transition to RUN, ready=1 on the next cycle. A clear takes exactly depth cycles of ready=0.
  - RUN with clr=1: go to CLEAR with the counter at 0. Requests accepted in the clr cycle complete normally, including their rvalid. clr during CLEAR is ignored.
- Reset values: dout 0, rvalid 0, misalign 0, counter 0.
  - CLEAR_ON_RESET=1: state CLEAR, ready 0.
  - CLEAR_ON_RESET=0: state RUN, ready 1.
  - Array contents are not reset.

## Timing
- Read accepted at edge N: dout and rvalid are valid after edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1). Back-to-back reads every cycle are fully pipelined.
- A write accepted at edge N is visible to a read accepted at edge N+1 on either port.
- misalign pulses after edge N+1 independent of OUT_REG.
- ready is registered. It falls on the edge after clr is sampled and rises on the edge after the last clear write.
- Reset mid-read: the pipeline flushes and no rvalid is issued for in-flight reads.
- Reset mid-clear: the counter restarts at 0 and the full clear reruns (CLEAR_ON_RESET=1).
- With OUT_REG=1, dout changes only on cycles where rvalid is high.

## Test plan
- Defaults: after rstn rises, ready stays 0 for 1024 cycles then goes to 1. Read addr 0x3FC gives douta=0x00000000 with rvalida one cycle after acceptance.
- Port A writes 0xDEADBEEF to 0x010 with bea=4'b1111. Port A then writes 0x000000AA with bea=4'b0001. Port B reads 0x010 and returns 0xDEADBEAA.
- Same cycle: A writes 0x11111111 (bea=4'b0011) and B writes 0x22222222 (beb=4'b0110) to 0x020. A later read of 0x020 returns 0x00221111.
- RDW_MODE=1, OUT_REG=1: port A writes 0x12345678 to 0x040 with a prior word of 0. douta=0x12345678 and rvalida arrive 2 cycles after acceptance. Repeat with RDW_MODE=0: no rvalida and douta holds its previous value.
- Read addr 0x013: returns the word at 0x010, and misaligna pulses one cycle after acceptance. An aligned read produces no misalign pulse.
- In RUN, pulse clr with a concurrent read on port B: that read completes. ready drops for depth cycles and all requests during that window give no rvalid. Memory reads zero afterward. Assert rstn low mid-clear: on release, ready=0 for a full depth cycles again.
